// File: rtl/des_pkg.sv
// Shared constants for the DES key schedule: PC-1/PC-2 tables, the rotation
// schedule, the FSM state type and the permutation helpers.
package des_pkg;

   localparam int KEY_W    = 64;
   localparam int HALF_W   = 28;
   localparam int SUBKEY_W = 48;
   localparam int ROUNDS   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Table entries use standard 1-based numbering, bit 1 being the MSB.
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   localparam logic [1:0] SHIFT_SCHED [ROUNDS] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   function automatic logic [55:0] pc1(input logic [KEY_W-1:0] key);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[55-i] = key[KEY_W-PC1[i]];
      return r;
   endfunction

   function automatic logic [SUBKEY_W-1:0] pc2(input logic [55:0] cd);
      logic [SUBKEY_W-1:0] r;
      r = '0;
      for (int i = 0; i < SUBKEY_W; i++) r[SUBKEY_W-1-i] = cd[56-PC2[i]];
      return r;
   endfunction

endpackage

// File: rtl/des_key_round.sv
// One key-schedule step: rotate C and D left by 1 or 2, then compress
// the rotated halves through PC-2 into a 48-bit subkey.
import des_pkg::*;

module des_key_round (
   input  logic [HALF_W-1:0]   c,
   input  logic [HALF_W-1:0]   d,
   input  logic [1:0]          shift,
   output logic [HALF_W-1:0]   c_next,
   output logic [HALF_W-1:0]   d_next,
   output logic [SUBKEY_W-1:0] subkey
);

   always_comb begin
      if (shift == 2'd2) begin
         c_next = {c[HALF_W-3:0], c[HALF_W-1:HALF_W-2]};
         d_next = {d[HALF_W-3:0], d[HALF_W-1:HALF_W-2]};
      end else begin
         c_next = {c[HALF_W-2:0], c[HALF_W-1]};
         d_next = {d[HALF_W-2:0], d[HALF_W-1]};
      end
   end

   assign subkey = pc2({c_next, d_next});

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: accepts a key, produces one subkey per clock
// for 16 cycles, then holds all 16 slots stable for the downstream DES core.
import des_pkg::*;

module des_key_schedule (
   input  logic                clk,
   input  logic                rst,
   input  logic [KEY_W-1:0]    key_in,
   input  logic                key_valid,
   output logic                key_ready,
   input  logic                decrypt,
   output logic                keys_valid,
   output logic [SUBKEY_W-1:0] key_1,
   output logic [SUBKEY_W-1:0] key_2,
   output logic [SUBKEY_W-1:0] key_3,
   output logic [SUBKEY_W-1:0] key_4,
   output logic [SUBKEY_W-1:0] key_5,
   output logic [SUBKEY_W-1:0] key_6,
   output logic [SUBKEY_W-1:0] key_7,
   output logic [SUBKEY_W-1:0] key_8,
   output logic [SUBKEY_W-1:0] key_9,
   output logic [SUBKEY_W-1:0] key_10,
   output logic [SUBKEY_W-1:0] key_11,
   output logic [SUBKEY_W-1:0] key_12,
   output logic [SUBKEY_W-1:0] key_13,
   output logic [SUBKEY_W-1:0] key_14,
   output logic [SUBKEY_W-1:0] key_15,
   output logic [SUBKEY_W-1:0] key_16
);

   state_t              state, state_next;
   logic [3:0]          round;
   logic                mode;
   logic [HALF_W-1:0]   c, d, c_next, d_next;
   logic [SUBKEY_W-1:0] subkey;
   logic [SUBKEY_W-1:0] slot [ROUNDS];
   logic [3:0]          slot_idx;
   logic                accept;

   assign key_ready  = (state != GEN);
   assign keys_valid = (state == DONE);
   assign accept     = key_valid && key_ready;
   // Decrypt mode fills the slots back to front so the core sees K16..K1.
   assign slot_idx   = mode ? (4'd15 - round) : round;

   des_key_round u_round (
      .c      (c),
      .d      (d),
      .shift  (SHIFT_SCHED[round]),
      .c_next (c_next),
      .d_next (d_next),
      .subkey (subkey)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: if (accept) state_next = GEN;
         GEN:        if (round == 4'd15) state_next = DONE;
         default:    state_next = IDLE;
      endcase
   end

   // NOTE: state is updated with <= so every register samples the pre-edge
   // values of its neighbours; a blocking = here would create ordering races.
   always_ff @(posedge clk) begin
      if (rst) begin
         round <= '0;
         mode  <= 1'b0;
         c     <= '0;
         d     <= '0;
         // NOTE: the slot array is reset on purpose because the slots are
         // outputs that must read zero after reset; plain storage would not be.
         for (int i = 0; i < ROUNDS; i++) slot[i] <= '0;
      end else if (accept) begin
         {c, d} <= pc1(key_in);
         mode   <= decrypt;
         round  <= '0;
      end else if (state == GEN) begin
         c              <= c_next;
         d              <= d_next;
         slot[slot_idx] <= subkey;
         round          <= round + 4'd1;
      end
   end

   assign key_1  = slot[0];
   assign key_2  = slot[1];
   assign key_3  = slot[2];
   assign key_4  = slot[3];
   assign key_5  = slot[4];
   assign key_6  = slot[5];
   assign key_7  = slot[6];
   assign key_8  = slot[7];
   assign key_9  = slot[8];
   assign key_10 = slot[9];
   assign key_11 = slot[10];
   assign key_12 = slot[11];
   assign key_13 = slot[12];
   assign key_14 = slot[13];
   assign key_15 = slot[14];
   assign key_16 = slot[15];

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Sequential DES key schedule that sits directly upstream of the DES core. It accepts a 64-bit key through a valid/ready handshake and generates one 48-bit subkey per clock over 16 cycles. It then holds all 16 subkeys stable on parallel outputs that wire straight into the core's key_1..key_16 inputs. A decrypt flag stores the subkeys in reverse order, so the same combinational core performs decryption.

Parameters:
None. The round count (16), PC-1/PC-2 tables and shift schedule are fixed by FIPS 46-3.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
key_in  input  64  DES key; bit 1 of the standard = key_in[63]; parity bits (8,16,..,64) ignored
key_valid  input  1  key_in/decrypt valid this cycle
key_ready  output  1  block can accept a key (IDLE or DONE)
decrypt  input  1  sampled with the key; 1 = store subkeys in reverse order
keys_valid  output  1  all 16 subkey outputs hold a complete, consistent schedule
key_1 .. key_16  output  48 each  subkey slots; slot n feeds the core's key_n; standard bit 1 = MSB

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE, key_ready=1, keys_valid=0, all key_n=0, round counter=0, C/D=0.
  - Reset overrides everything, including mid-generation; a partial schedule is discarded and all slots read 0.
- States:
  - IDLE: key_ready=1, keys_valid=0.
  - GEN: key_ready=0, keys_valid=0, 16 cycles.
  - DONE: key_ready=1, keys_valid=1.
- Accept: a handshake occurs at an edge where key_valid && key_ready.
  - At that edge the block loads PC-1(key_in) into C (28b, upper) and D (28b, lower), latches decrypt into a mode register, clears round=0 and goes to GEN.
  - From DONE, keys_valid falls the cycle after the accept. Old subkeys stay visible but are invalid until overwritten.
- GEN, round r = 0..15, one per cycle:
  - shift s=1 for r in {0,1,8,15}, else s=2.
  - C', D' = C, D each rotated left by s (28-bit rotation, wrap MSB→LSB); C, D <= C', D'.
  - K = PC-2({C',D'}).
  - Write K into slot r+1 when mode=encrypt, or into slot 16-r when mode=decrypt. Only one slot is written per cycle.
  - At r=15: state <= DONE, keys_valid <= 1 on the same edge that writes the last slot.
- Latency: keys_valid is 1 exactly 16 clocks after the accepting edge. Throughput is one schedule per 17 cycles when keys are offered back-to-back (accept in DONE).
- After 16 rounds, total rotation is 28, so C/D return to the PC-1 value. This serves as a self-check and is used as a bench assertion.
- key_valid while key_ready=0 (during GEN) is ignored with no side effect. The upstream must hold key_valid until it sees key_ready.
- decrypt changing outside an accept has no effect.
- DONE persists indefinitely until a new accept or reset.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package des_pkg:
  - PC1 table (56 entries) and PC2 table (48 entries) as constants.
  - SHIFT_SCHED constant (16 entries of 1/2).
  - State enum (IDLE, GEN, DONE).
  - Widths: KEY_W=64, HALF_W=28, SUBKEY_W=48.
- Sub-module des_key_round (combinational):
  - Inputs: C, D, shift amount. Outputs: C', D', 48-bit subkey.
  - Instantiated once and reused every cycle.
- The top level holds the FSM, counter, mode register, C/D registers and the 16 subkey slots.

Test Plan:
- Encrypt: rst then key_in=133457799BBCDFF1, decrypt=0, one-cycle key_valid.
  - Required: key_ready=0 for 16 cycles; keys_valid rises 16 clocks after accept.
  - Required: key_1=1B02EFFC7072, key_2=79AED9DBC9E5, key_16=CB3D8B0E17F5.
- Decrypt: same key with decrypt=1.
  - Required: key_1=CB3D8B0E17F5, key_15=79AED9DBC9E5, key_16=1B02EFFC7072.
- Core integration: feed outputs to the DES core with data 0123456789ABCDEF.
  - Encrypt gives 85E813540F0AB405.
  - Re-schedule with decrypt=1 and feed 85E813540F0AB405; the result returns 0123456789ABCDEF.
- Busy ignore: assert key_valid with key 0000000000000000 during GEN cycle 5.
  - Required: no effect; the final schedule still matches the first accepted key.
  - Required: C/D after round 15 equal PC-1(key).
- Back-to-back: in DONE, accept a second key (FFFFFFFFFFFFFFFF) in the same cycle key_valid is seen.
  - Required: keys_valid=0 on the next cycle; 16 clocks later all key_n=FFFFFFFFFFFF.
- Reset mid-op: assert rst at GEN cycle 8.
  - Required: the next cycle shows keys_valid=0, key_ready=1 and all key_n=0.
  - Required: a following accept completes normally.
